// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and types for the EX->MEM pipeline register.
// Also holds the per-edge action the register takes.
package ex_mem_reg_pkg;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
    localparam logic        WRITE_DISABLE = 1'b0;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } ex_mem_act_e;

endpackage

// File: rtl/ex_mem_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Used to count the bubbles sent on to mem.
module ex_mem_reg_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    import ex_mem_reg_pkg::*;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: forwards the ex result, inserts bubbles under stall,
// flushes on exception, and returns multi-cycle accumulate state to ex.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 2,
    parameter int BUB_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [4:0]         ex_wd,
    input  logic               ex_wreg,
    input  logic [31:0]        ex_wdata,
    input  logic               ex_whilo,
    input  logic [31:0]        ex_hi,
    input  logic [31:0]        ex_lo,
    input  logic [63:0]        hilo_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic [4:0]         mem_wd,
    output logic               mem_wreg,
    output logic [31:0]        mem_wdata,
    output logic               mem_whilo,
    output logic [31:0]        mem_hi,
    output logic [31:0]        mem_lo,
    output logic [63:0]        hilo_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [BUB_W-1:0]   bubble_cnt
);

    ex_mem_act_e act;

    // stall[EX]=0 with stall[MEM]=1 cannot come from ctrl; it falls through to hold.
    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall[STALL_EX] && !stall[STALL_MEM]) begin
            act = ACT_BUBBLE;
        end else if (!stall[STALL_EX] && !stall[STALL_MEM]) begin
            act = ACT_ADVANCE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            mem_wd    <= NOP_REG_ADDR;
            mem_wreg  <= WRITE_DISABLE;
            mem_wdata <= ZERO_WORD;
            mem_whilo <= WRITE_DISABLE;
            mem_hi    <= ZERO_WORD;
            mem_lo    <= ZERO_WORD;
            hilo_o    <= {ZERO_WORD, ZERO_WORD};
            cnt_o     <= '0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    mem_wd    <= NOP_REG_ADDR;
                    mem_wreg  <= WRITE_DISABLE;
                    mem_wdata <= ZERO_WORD;
                    mem_whilo <= WRITE_DISABLE;
                    mem_hi    <= ZERO_WORD;
                    mem_lo    <= ZERO_WORD;
                    // A bubble keeps ex's accumulate state alive; a flush drops it.
                    if (act == ACT_BUBBLE) begin
                        hilo_o <= hilo_i;
                        cnt_o  <= cnt_i;
                    end else begin
                        hilo_o <= {ZERO_WORD, ZERO_WORD};
                        cnt_o  <= '0;
                    end
                end
                ACT_ADVANCE: begin
                    mem_wd    <= ex_wd;
                    mem_wreg  <= ex_wreg;
                    mem_wdata <= ex_wdata;
                    mem_whilo <= ex_whilo;
                    mem_hi    <= ex_hi;
                    mem_lo    <= ex_lo;
                    hilo_o    <= {ZERO_WORD, ZERO_WORD};
                    cnt_o     <= '0;
                end
                default: ;
            endcase
        end
    end

    ex_mem_reg_sat_counter #(
        .W (BUB_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_BUBBLE),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus random traffic, scored against
// a reference model of the register's per-edge rules.
module tb_ex_mem_reg;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [15:0] bub;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    obs_t exp_q[$];
    obs_t model;
    int   n_checks;
    int   n_pass;

    ex_mem_reg dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .ex_wdata   (ex_wdata),
        .ex_whilo   (ex_whilo),
        .ex_hi      (ex_hi),
        .ex_lo      (ex_lo),
        .hilo_i     (hilo_i),
        .cnt_i      (cnt_i),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_whilo  (mem_whilo),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .hilo_o     (hilo_o),
        .cnt_o      (cnt_o),
        .bubble_cnt (bubble_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic rand_ex();
        ex_wd    = 5'($urandom_range(0, 31));
        ex_wreg  = 1'($urandom_range(0, 1));
        ex_wdata = $urandom;
        ex_whilo = 1'($urandom_range(0, 1));
        ex_hi    = $urandom;
        ex_lo    = $urandom;
        hilo_i   = {$urandom, $urandom};
        cnt_i    = 2'($urandom_range(0, 3));
    endtask

    // Applies one edge and pushes what mem/ex must see after it.
    task automatic step(input logic r, input logic f, input logic [5:0] s);
        rst   = r;
        flush = f;
        stall = s;
        @(posedge clk);
        #1;
        if (r) begin
            model = '0;
        end else if (f) begin
            model = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0, whilo: 1'b0, hi: 32'd0,
                      lo: 32'd0, hilo: 64'd0, cnt: 2'd0, bub: model.bub};
        end else if (s[3] && !s[4]) begin
            model = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0, whilo: 1'b0, hi: 32'd0,
                      lo: 32'd0, hilo: hilo_i, cnt: cnt_i,
                      bub: (model.bub == 16'hFFFF) ? 16'hFFFF : model.bub + 16'd1};
        end else if (!s[3] && !s[4]) begin
            model = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                      hi: ex_hi, lo: ex_lo, hilo: 64'd0, cnt: 2'd0, bub: model.bub};
        end
        exp_q.push_back(model);
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            chk("mem_wd",     64'(mem_wd),     64'(e.wd));
            chk("mem_wreg",   64'(mem_wreg),   64'(e.wreg));
            chk("mem_wdata",  64'(mem_wdata),  64'(e.wdata));
            chk("mem_whilo",  64'(mem_whilo),  64'(e.whilo));
            chk("mem_hi",     64'(mem_hi),     64'(e.hi));
            chk("mem_lo",     64'(mem_lo),     64'(e.lo));
            chk("hilo_o",     hilo_o,          e.hilo);
            chk("cnt_o",      64'(cnt_o),      64'(e.cnt));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
        end
    end

    // stimulus
    initial begin
        logic [5:0] pick;
        n_checks = 0;
        n_pass   = 0;
        model    = '0;
        rst = 1'b1; flush = 1'b0; stall = 6'd0;
        rand_ex();

        // reset with nonzero inputs and a competing flush/stall
        step(1'b1, 1'b1, 6'b001111);
        rand_ex();
        step(1'b1, 1'b0, 6'b000000);

        // plain advance
        ex_wd = 5'h03; ex_wreg = 1'b1; ex_wdata = 32'h0000_F0F0;
        step(1'b0, 1'b0, 6'b000000);

        // two-cycle madd: bubble carries state, release clears it
        hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
        step(1'b0, 1'b0, 6'b001111);
        ex_wd = 5'h1F; ex_wdata = 32'h1234_5678; ex_whilo = 1'b1;
        ex_hi = 32'h0000_0001; ex_lo = 32'h0000_0004;
        step(1'b0, 1'b0, 6'b000000);

        // hold for three cycles after a load
        ex_wdata = 32'hA5A5_A5A5;
        step(1'b0, 1'b0, 6'b000000);
        rand_ex();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b011111);
        step(1'b0, 1'b0, 6'b010000);

        // bubble then flush while ex would bubble
        step(1'b0, 1'b0, 6'b001111);
        step(1'b0, 1'b1, 6'b001111);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_ex();
            case ($urandom_range(0, 4))
                0: pick = 6'b000000;
                1: pick = 6'b001111;
                2: pick = 6'b011111;
                3: pick = 6'b010000;
                default: pick = 6'($urandom_range(0, 63));
            endcase
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 14) == 0), pick);
        end

        // drive the bubble counter into saturation and one past it
        while (model.bub != 16'hFFFF) step(1'b0, 1'b0, 6'b001111);
        rand_ex();
        step(1'b0, 1'b0, 6'b001111);
        step(1'b0, 1'b0, 6'b000111);

        // drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
